spike_count_argmax: RTL and testbench
=====================================

// Module: spike_count_argmax
// PURPOSE
//  Readout stage directly downstream of the matrix LIF stage. Streams the stored spike matrix
//  (one 16-bit word per neuron per timestep) from on-chip RAM and counts spikes per output neuron.
//  Reports the winning neuron (highest count, i.e. the classification) and optionally writes
//  per-neuron counts back to RAM.
// PARAMETERS
//  ADDR_W  14  RAM address width
//  DIM_W   10  neuron/timestep count width
//  CNT_W   16  spike counter width; saturates at all-ones
// PORTS
//  clk                 in   1       single clock
//  reset               in   1       synchronous, active-high
//  start               in   1       level; sampled only in IDLE
//  done                out  1       high when idle/finished
//  src_start_address   in   ADDR_W  base of spike matrix
//  src_address         out  ADDR_W  spike RAM read address
//  src_readdata        in   16      spike word; 1-cycle synchronous read latency
//  src_write_en        out  1       constant 0
//  num_neurons         in   DIM_W   N, output neurons (columns)
//  num_steps           in   DIM_W   T, timesteps per neuron (rows)
//  dest_start_address  in   ADDR_W  base of count vector (writeback feature only)
//  dest_address        out  ADDR_W  count write address
//  dest_writedata      out  16      spike count, zero-extended
//  dest_write_en       out  1       1-cycle write strobe
//  winner              out  DIM_W   index of max-count neuron, valid while done=1
//  winner_count        out  CNT_W   count of winner
// BEHAVIOUR
//  - Clock/reset: one clock, clk; reset is synchronous and active-high, named reset.
//  - Layout: neuron-major; word for neuron n, step t at src_start_address + n*T + t.
//  - Spike: src_readdata[14:0] != 0 (covers 16'h0001 and FP16 1.0; +/-0 is no spike).
//  - Reset values: state IDLE, done=1, src_address=src_start_address, dest_address=dest_start_address,
//    dest_writedata=0, dest_write_en=0, winner=0, winner_count=0, all counters 0.
//  - FSM:
//    - IDLE: done=1. start=1 -> INIT, done<=0.
//    - INIT: src_address<=src_start_address; best<=0, best_idx<=0.
//      N==0 or T==0 -> FINISH; else RUN.
//    - RUN: one address per cycle, +1 per cycle; step/neuron counters advance step-fastest.
//      A valid/last-step tag pipeline is delayed 1 cycle to line up with src_readdata.
//      After issuing address N*T-1 -> DRAIN.
//    - DRAIN: consumes the last datum (1 cycle) -> FINISH.
//    - FINISH: winner<=best_idx, winner_count<=best, done<=1 -> IDLE.
//  - Accumulate: on each tagged-valid datum cnt<=cnt+spike, saturating.
//    - On the last-step datum, compare final count to best; strictly greater replaces best.
//    - Ties therefore keep the lowest index. cnt clears for the next neuron in the same cycle.
//  - Latency: done rises N*T+4 edges after the edge that samples start in IDLE; 3 edges when N or T is 0.
//  - start while busy is ignored. Inputs are sampled each cycle and must be held stable while done=0.
//  - winner/winner_count hold their previous values until FINISH.
//  - Reset mid-operation: immediate return to IDLE with reset values; any writeback in flight is dropped.
// CONFIGURATION
//  COUNT_WRITEBACK_EN
//    defined: on each neuron's last-step datum, the next edge drives
//             dest_address=dest_start_address+n, dest_writedata=final count (saturated), dest_write_en=1 for one cycle.
//    undefined: dest_write_en tied 0, dest_address/dest_writedata held at reset values. Winner logic unchanged.
// STRUCTURE
//  - snn_defs package/include: ADDR_W, DIM_W, CNT_W defaults, FP16_ONE=16'h3C00,
//    FP16_NEG_ONE=16'hBC00, FSM state encodings.
//  - Sub-module argmax_tracker: clk, reset, clear, valid, idx, value -> best_idx, best_value.
//    Strict-greater update; shared with future readout stages.
//  - Top level holds the FSM, address generation, latency alignment and the per-neuron counter.
// TESTING
//  1. N=4, T=8, spike counts {2,7,3,7} -> winner=1, winner_count=7; done after 36 edges.
//  2. All-zero matrix, N=3, T=5 -> winner=0, winner_count=0.
//     Words 16'h8000 (-0) present in the matrix count as no spike.
//  3. N=2, T=4, words mixing 16'h0001 and 16'h3C00 -> both count as spikes; winner=higher-count neuron.
//  4. N=0 -> no valid reads, done back after 3 edges, winner=0.
//  5. Reset asserted at RUN cycle 5 of a N=4, T=8 run:
//     - next edge: done=1, no dest_write_en, winner=0.
//     - a fresh start then completes correctly.
//  6. COUNT_WRITEBACK_EN defined, N=4, T=8 -> exactly 4 one-cycle strobes, dest_address base+0..3 with counts.
//     Undefined -> zero strobes.

Source files
------------

// File: rtl/snn_defs_pkg.sv
// Shared SNN readout definitions: default widths, FP16 spike encodings and FSM state encoding.
package snn_defs_pkg;

    localparam int DEF_ADDR_W = 14;
    localparam int DEF_DIM_W  = 10;
    localparam int DEF_CNT_W  = 16;

    localparam logic [15:0] FP16_ONE     = 16'h3C00;
    localparam logic [15:0] FP16_NEG_ONE = 16'hBC00;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    // Any non-zero magnitude is a spike, so integer 1 and FP16 +/-1.0 both count; +/-0 does not.
    function automatic logic is_spike(input logic [15:0] word);
        return (word & 16'h7FFF) != 16'h0000;
    endfunction

endpackage

// File: rtl/argmax_tracker.sv
// Running argmax: keeps the first index holding the strictly largest value seen since clear.
module argmax_tracker #(
    parameter int IDX_W = 10,
    parameter int VAL_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             valid,
    input  logic [IDX_W-1:0] idx,
    input  logic [VAL_W-1:0] value,
    output logic [IDX_W-1:0] best_idx,
    output logic [VAL_W-1:0] best_value
);

    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic [VAL_W-1:0] best_value_q, best_value_d;

    always_comb begin
        best_idx_d   = best_idx_q;
        best_value_d = best_value_q;
        if (clear) begin
            best_idx_d   = '0;
            best_value_d = '0;
        end else if (valid && (value > best_value_q)) begin
            best_idx_d   = idx;
            best_value_d = value;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            best_idx_q   <= '0;
            best_value_q <= '0;
        end else begin
            best_idx_q   <= best_idx_d;
            best_value_q <= best_value_d;
        end
    end

    assign best_idx   = best_idx_q;
    assign best_value = best_value_q;

endmodule

// File: rtl/spike_count_argmax.sv
// Streams a neuron-major spike matrix from RAM, counts spikes per neuron and reports the argmax.
// Optional per-neuron count writeback is enabled by defining COUNT_WRITEBACK_EN.
module spike_count_argmax
    import snn_defs_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DIM_W  = DEF_DIM_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    input  logic [ADDR_W-1:0] src_start_address,
    output logic [ADDR_W-1:0] src_address,
    input  logic [15:0]       src_readdata,
    output logic              src_write_en,
    input  logic [DIM_W-1:0]  num_neurons,
    input  logic [DIM_W-1:0]  num_steps,
    input  logic [ADDR_W-1:0] dest_start_address,
    output logic [ADDR_W-1:0] dest_address,
    output logic [15:0]       dest_writedata,
    output logic              dest_write_en,
    output logic [DIM_W-1:0]  winner,
    output logic [CNT_W-1:0]  winner_count
);

    state_t            state_q, state_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] src_address_q, src_address_d;
    logic [DIM_W-1:0]  step_q, step_d;
    logic [DIM_W-1:0]  neuron_q, neuron_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tag_valid_q, tag_valid_d;
    logic              tag_last_q, tag_last_d;
    logic [DIM_W-1:0]  tag_idx_q, tag_idx_d;
    logic [DIM_W-1:0]  winner_q, winner_d;
    logic [CNT_W-1:0]  winner_count_q, winner_count_d;

    logic              last_step, last_issue, tracker_clear, final_datum;
    logic [CNT_W-1:0]  cnt_sum;
    logic [DIM_W-1:0]  best_idx;
    logic [CNT_W-1:0]  best_value;

    assign last_step   = (step_q == num_steps - DIM_W'(1));
    assign last_issue  = last_step && (neuron_q == num_neurons - DIM_W'(1));
    assign final_datum = tag_valid_q && tag_last_q;
    assign cnt_sum     = (is_spike(src_readdata) && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_INIT;
            ST_INIT:   state_d = (num_neurons == '0 || num_steps == '0) ? ST_FINISH : ST_RUN;
            ST_RUN:    if (last_issue) state_d = ST_DRAIN;
            ST_DRAIN:  state_d = ST_FINISH;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        done_d         = done_q;
        src_address_d  = src_address_q;
        step_d         = step_q;
        neuron_d       = neuron_q;
        tag_valid_d    = 1'b0;
        tag_last_d     = 1'b0;
        tag_idx_d      = tag_idx_q;
        winner_d       = winner_q;
        winner_count_d = winner_count_q;
        tracker_clear  = 1'b0;
        cnt_d          = cnt_q;

        // Data trails its address by one cycle, so accumulation keys off the delayed tag.
        if (tag_valid_q) cnt_d = tag_last_q ? '0 : cnt_sum;

        case (state_q)
            ST_IDLE: if (start) done_d = 1'b0;
            ST_INIT: begin
                src_address_d = src_start_address;
                step_d        = '0;
                neuron_d      = '0;
                cnt_d         = '0;
                tracker_clear = 1'b1;
            end
            ST_RUN: begin
                src_address_d = src_address_q + ADDR_W'(1);
                tag_valid_d   = 1'b1;
                tag_last_d    = last_step;
                tag_idx_d     = neuron_q;
                step_d        = last_step ? '0 : step_q + DIM_W'(1);
                neuron_d      = last_step ? neuron_q + DIM_W'(1) : neuron_q;
            end
            ST_FINISH: begin
                winner_d       = best_idx;
                winner_count_d = best_value;
                done_d         = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            done_q         <= 1'b1;
            src_address_q  <= src_start_address;
            step_q         <= '0;
            neuron_q       <= '0;
            cnt_q          <= '0;
            tag_valid_q    <= 1'b0;
            tag_last_q     <= 1'b0;
            tag_idx_q      <= '0;
            winner_q       <= '0;
            winner_count_q <= '0;
        end else begin
            state_q        <= state_d;
            done_q         <= done_d;
            src_address_q  <= src_address_d;
            step_q         <= step_d;
            neuron_q       <= neuron_d;
            cnt_q          <= cnt_d;
            tag_valid_q    <= tag_valid_d;
            tag_last_q     <= tag_last_d;
            tag_idx_q      <= tag_idx_d;
            winner_q       <= winner_d;
            winner_count_q <= winner_count_d;
        end
    end

    argmax_tracker #(.IDX_W(DIM_W), .VAL_W(CNT_W)) u_argmax (
        .clk        (clk),
        .reset      (reset),
        .clear      (tracker_clear),
        .valid      (final_datum),
        .idx        (tag_idx_q),
        .value      (cnt_sum),
        .best_idx   (best_idx),
        .best_value (best_value)
    );

`ifdef COUNT_WRITEBACK_EN
    logic [ADDR_W-1:0] dest_address_q, dest_address_d;
    logic [15:0]       dest_writedata_q, dest_writedata_d;
    logic              dest_write_en_q, dest_write_en_d;

    always_comb begin
        dest_address_d   = dest_address_q;
        dest_writedata_d = dest_writedata_q;
        dest_write_en_d  = final_datum;
        if (final_datum) begin
            dest_address_d   = dest_start_address + ADDR_W'(tag_idx_q);
            dest_writedata_d = 16'(cnt_sum);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dest_address_q   <= dest_start_address;
            dest_writedata_q <= '0;
            dest_write_en_q  <= 1'b0;
        end else begin
            dest_address_q   <= dest_address_d;
            dest_writedata_q <= dest_writedata_d;
            dest_write_en_q  <= dest_write_en_d;
        end
    end

    assign dest_address   = dest_address_q;
    assign dest_writedata = dest_writedata_q;
    assign dest_write_en  = dest_write_en_q;
`else
    assign dest_address   = dest_start_address;
    assign dest_writedata = '0;
    assign dest_write_en  = 1'b0;
`endif

    assign done         = done_q;
    assign src_address  = src_address_q;
    assign src_write_en = 1'b0;
    assign winner       = winner_q;
    assign winner_count = winner_count_q;

endmodule

// File: tb/tb_spike_count_argmax.sv
// Directed bench for spike_count_argmax with a 1-cycle synchronous spike RAM model.
module tb_spike_count_argmax;
    import snn_defs_pkg::*;

    localparam int ADDR_W = 14;
    localparam int DIM_W  = 10;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              done;
    logic [ADDR_W-1:0] src_start_address;
    logic [ADDR_W-1:0] src_address;
    logic [15:0]       src_readdata;
    logic              src_write_en;
    logic [DIM_W-1:0]  num_neurons;
    logic [DIM_W-1:0]  num_steps;
    logic [ADDR_W-1:0] dest_start_address;
    logic [ADDR_W-1:0] dest_address;
    logic [15:0]       dest_writedata;
    logic              dest_write_en;
    logic [DIM_W-1:0]  winner;
    logic [CNT_W-1:0]  winner_count;

    int checks   = 0;
    int failures = 0;

    logic [15:0]       mem [0:16383];
    int                wb_total = 0;
    logic [ADDR_W-1:0] wb_addr [0:63];
    logic [15:0]       wb_data [0:63];

    always #5 clk = ~clk;

    always @(posedge clk) src_readdata <= mem[src_address];

    always @(negedge clk) begin
        if (dest_write_en === 1'b1) begin
            if (wb_total < 64) begin
                wb_addr[wb_total] = dest_address;
                wb_data[wb_total] = dest_writedata;
            end
            wb_total++;
        end
    end

    spike_count_argmax #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .CNT_W(CNT_W)) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .done               (done),
        .src_start_address  (src_start_address),
        .src_address        (src_address),
        .src_readdata       (src_readdata),
        .src_write_en       (src_write_en),
        .num_neurons        (num_neurons),
        .num_steps          (num_steps),
        .dest_start_address (dest_start_address),
        .dest_address       (dest_address),
        .dest_writedata     (dest_writedata),
        .dest_write_en      (dest_write_en),
        .winner             (winner),
        .winner_count       (winner_count)
    );

    // Neuron n gets k spike words (value w) followed by -0 words for the rest of its T steps.
    task automatic load_neuron(input int base, input int t_len, input int n, input int k,
                               input logic [15:0] w);
        for (int t = 0; t < t_len; t++)
            mem[base + n * t_len + t] = (t < k) ? w : 16'h8000;
    endtask

    // Pulses start, counts edges (the sampling edge is edge 1) until done, then checks results.
    task automatic run_job(input int n, input int t_len, input int base, input int exp_edges,
                           input int exp_win, input int exp_cnt, input string name,
                           input bit hold_start);
        int edges;
        num_neurons       = DIM_W'(n);
        num_steps         = DIM_W'(t_len);
        src_start_address = ADDR_W'(base);
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        edges = 1;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy: done=%b required 0", name, done);
        end
        while (done !== 1'b1 && edges < 2000) begin
            @(posedge clk); #1;
            edges++;
        end
        start = 1'b0;
        checks++;
        if (edges != exp_edges) begin
            failures++;
            $display("FAIL %s_latency: edges=%0d required %0d", name, edges, exp_edges);
        end
        checks++;
        if (winner !== DIM_W'(exp_win)) begin
            failures++;
            $display("FAIL %s_winner: got %0d required %0d", name, winner, exp_win);
        end
        checks++;
        if (winner_count !== CNT_W'(exp_cnt)) begin
            failures++;
            $display("FAIL %s_winner_count: got %0d required %0d", name, winner_count, exp_cnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        src_start_address  = 14'd100;
        dest_start_address = 14'd2000;
        num_neurons = '0;
        num_steps   = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || winner !== '0 || winner_count !== '0) begin
            failures++;
            $display("FAIL reset_outputs: done=%b winner=%0d count=%0d required 1/0/0",
                     done, winner, winner_count);
        end
        checks++;
        if (src_address !== 14'd100 || dest_address !== 14'd2000) begin
            failures++;
            $display("FAIL reset_addresses: src=%0d dest=%0d required 100/2000",
                     src_address, dest_address);
        end
        checks++;
        if (dest_write_en !== 1'b0 || dest_writedata !== 16'h0 || src_write_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_writes: dwe=%b dwd=%0h swe=%b required 0/0/0",
                     dest_write_en, dest_writedata, src_write_en);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic load_basic();
        load_neuron(100, 8, 0, 2, 16'h0001);
        load_neuron(100, 8, 1, 7, 16'h0001);
        load_neuron(100, 8, 2, 3, FP16_ONE);
        load_neuron(100, 8, 3, 7, 16'h0001);
    endtask

    // Counts {2,7,3,7}: the tie at 7 must keep the lower index.
    task automatic test_basic();
        load_basic();
        run_job(4, 8, 100, 36, 1, 7, "basic", 1'b0);
    endtask

    task automatic test_all_zero();
        for (int i = 0; i < 15; i++) mem[500 + i] = (i % 2 == 0) ? 16'h8000 : 16'h0000;
        run_job(3, 5, 500, 19, 0, 0, "all_zero", 1'b0);
    endtask

    task automatic test_zero_dims();
        int wb_start;
        wb_start = wb_total;
        run_job(0, 5, 100, 3, 0, 0, "n_zero", 1'b0);
        run_job(3, 0, 100, 3, 0, 0, "t_zero", 1'b0);
        checks++;
        if (wb_total != wb_start) begin
            failures++;
            $display("FAIL zero_dims_strobes: got %0d required 0", wb_total - wb_start);
        end
    endtask

    // Mixed integer and FP16 encodings; start held high throughout must not retrigger.
    task automatic test_mixed_encodings();
        mem[300] = 16'h0001; mem[301] = FP16_ONE;     mem[302] = 16'h0000; mem[303] = 16'h8000;
        mem[304] = FP16_ONE; mem[305] = 16'h0001;     mem[306] = FP16_NEG_ONE; mem[307] = FP16_ONE;
        run_job(2, 4, 300, 12, 1, 4, "mixed", 1'b1);
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL mixed_idle_after: done=%b required 1", done);
        end
    endtask

    task automatic test_reset_mid_run();
        int wb_start;
        load_basic();
        wb_start = wb_total;
        num_neurons       = 10'd4;
        num_steps         = 10'd8;
        src_start_address = 14'd100;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || dest_write_en !== 1'b0) begin
            failures++;
            $display("FAIL midrst_state: done=%b dwe=%b required 1/0", done, dest_write_en);
        end
        checks++;
        if (winner !== '0 || winner_count !== '0) begin
            failures++;
            $display("FAIL midrst_winner: winner=%0d count=%0d required 0/0", winner, winner_count);
        end
        checks++;
        if (wb_total != wb_start) begin
            failures++;
            $display("FAIL midrst_strobes: got %0d required 0", wb_total - wb_start);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        run_job(4, 8, 100, 36, 1, 7, "after_reset", 1'b0);
    endtask

    task automatic test_writeback();
        int wb_start;
        int exp_strobes;
        int exp_counts [4];
        exp_counts = '{2, 7, 3, 7};
`ifdef COUNT_WRITEBACK_EN
        exp_strobes = 4;
`else
        exp_strobes = 0;
`endif
        load_basic();
        wb_start = wb_total;
        run_job(4, 8, 100, 36, 1, 7, "writeback", 1'b0);
        @(posedge clk); #1;
        checks++;
        if (wb_total - wb_start != exp_strobes) begin
            failures++;
            $display("FAIL wb_strobes: got %0d required %0d", wb_total - wb_start, exp_strobes);
        end
        if (wb_total - wb_start == exp_strobes) begin
            for (int i = 0; i < exp_strobes; i++) begin
                checks++;
                if (wb_addr[wb_start + i] !== ADDR_W'(2000 + i) ||
                    wb_data[wb_start + i] !== 16'(exp_counts[i])) begin
                    failures++;
                    $display("FAIL wb_entry%0d: addr=%0d data=%0d required %0d/%0d", i,
                             wb_addr[wb_start + i], wb_data[wb_start + i], 2000 + i, exp_counts[i]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 16'h0000;
        test_reset();
        test_basic();
        test_all_zero();
        test_zero_dims();
        test_mixed_encodings();
        test_reset_mid_run();
        test_writeback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
